// File: rtl/mux_seq_pkg.sv
// Shared constants for the mux select sequencer.
// Mode encodings, channel count and channel indices.
package mux_seq_pkg;
   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;
   localparam int   N_CH        = 4;
   localparam logic [1:0] CH_A  = 2'd0;
   localparam logic [1:0] CH_B  = 2'd1;
   localparam logic [1:0] CH_C  = 2'd2;
   localparam logic [1:0] CH_D  = 2'd3;
endpackage

// File: rtl/mux_select_sequencer_if.sv
// Control and select bundle between the sequencer and its driver.
// The master drives the controls; the slave returns select and enable.
interface mux_select_sequencer_if #(
   parameter int CNT_W = 27
);
   logic             Mode;
   logic             Step;
   logic             Hold;
   logic [3:0]       Mask;
   logic [CNT_W-1:0] Dwell;
   logic [1:0]       Sel;
   logic             Enable;
   logic             Advance;

   modport master (
      output Mode, Step, Hold, Mask, Dwell,
      input  Sel, Enable, Advance
   );

   modport slave (
      input  Mode, Step, Hold, Mask, Dwell,
      output Sel, Enable, Advance
   );
endinterface

// File: rtl/mux_next_channel.sv
// Rotate-priority search for the next enabled channel after cur.
// Falls back to cur itself when the mask is empty.
module mux_next_channel (
   input  logic [1:0] cur,
   input  logic [3:0] mask,
   output logic [1:0] nxt,
   output logic       found
);
   logic [1:0] idx;

   // Walk from farthest to nearest so the nearest set bit wins.
   always_comb begin
      nxt = cur;
      idx = cur;
      for (int i = 4; i >= 1; i--) begin
         idx = cur + 2'(i);
         if (mask[idx]) nxt = idx;
      end
   end

   assign found = |mask;
endmodule

// File: rtl/mux_select_sequencer.sv
// Sel/Enable sequencer for a 4:1 mux with manual step and auto-scan.
// Holds the dwell counter, Step edge detect and output registers.
module mux_select_sequencer
   import mux_seq_pkg::*;
#(
   parameter int CNT_W = 27,
   parameter int N_CH  = 4
) (
   input  logic clk,
   input  logic rst_n,
   mux_select_sequencer_if.slave bus
);
   if (N_CH != 4) begin : g_bad_nch
      $error("N_CH must be 4 to match the 2-bit Sel");
   end

   logic             step_d;
   logic             mode_d;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       nxt;
   logic [1:0]       sel_next;
   logic             found;
   logic             step_rise;
   logic             mode_chg;
   logic             adv;
   logic             cnt_clr;

   mux_next_channel u_next (
      .cur   (bus.Sel),
      .mask  (bus.Mask),
      .nxt   (nxt),
      .found (found)
   );

   assign step_rise = bus.Step & ~step_d;
   assign mode_chg  = bus.Mode != mode_d;

   // A dropped current channel forces a reselect ahead of Step/Hold.
   always_comb begin
      adv = 1'b0;
      priority case (1'b1)
         !found:                   adv = 1'b0;
         !bus.Mask[bus.Sel]:       adv = 1'b1;
         bus.Mode == MODE_MANUAL:  adv = step_rise;
         default:
            adv = ~bus.Hold & (cnt >= bus.Dwell);
      endcase
   end

   assign cnt_clr  = adv | mode_chg | !found
                   | (bus.Mode == MODE_MANUAL);
   assign sel_next = adv ? nxt : bus.Sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_d      <= 1'b0;
         mode_d      <= MODE_MANUAL;
         cnt         <= '0;
         bus.Sel     <= CH_A;
         bus.Enable  <= 1'b0;
         bus.Advance <= 1'b0;
      end else begin
         step_d <= bus.Step;
         mode_d <= bus.Mode;
         if (cnt_clr)
            cnt <= '0;
         else if (!bus.Hold)
            cnt <= cnt + 1'b1;
         bus.Sel     <= sel_next;
         bus.Enable  <= found & bus.Mask[sel_next];
         bus.Advance <= adv & (nxt != bus.Sel);
      end
   end
endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed vector bench for mux_select_sequencer.
// Table of per-cycle vectors plus reset and dwell-lowering sequences.
module tb_mux_select_sequencer;
   localparam int CNT_W = 27;

   typedef struct {
      logic             mode;
      logic             step;
      logic             hold;
      logic [3:0]       mask;
      logic [CNT_W-1:0] dwell;
      logic [1:0]       sel;
      logic             en;
      logic             adv;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t vecs[$];

   mux_select_sequencer_if #(.CNT_W(CNT_W)) bus ();

   mux_select_sequencer #(.CNT_W(CNT_W), .N_CH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(
      input logic m, input logic s, input logic h,
      input logic [3:0] mk, input int dw,
      input logic [1:0] sl, input logic e, input logic a
   );
      vec_t v;
      v.mode  = m;
      v.step  = s;
      v.hold  = h;
      v.mask  = mk;
      v.dwell = CNT_W'(dw);
      v.sel   = sl;
      v.en    = e;
      v.adv   = a;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic m, input logic s, input logic h,
                        input logic [3:0] mk, input int dw);
      bus.Mode  = m;
      bus.Step  = s;
      bus.Hold  = h;
      bus.Mask  = mk;
      bus.Dwell = CNT_W'(dw);
   endtask

   task automatic check_out(input string tag, input logic [1:0] sl,
                            input logic e, input logic a);
      check({tag, ".sel"}, int'(bus.Sel), int'(sl));
      check({tag, ".en"},  int'(bus.Enable), int'(e));
      check({tag, ".adv"}, int'(bus.Advance), int'(a));
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // manual: held Step gives one advance, then three pulses wrap
      add(0,1,0,4'b1111,3, 1,1,1);
      for (int i = 0; i < 4; i++) add(0,1,0,4'b1111,3, 1,1,0);
      add(0,0,0,4'b1111,3, 1,1,0);
      add(0,1,0,4'b1111,3, 2,1,1);
      add(0,0,0,4'b1111,3, 2,1,0);
      add(0,1,0,4'b1111,3, 3,1,1);
      add(0,0,0,4'b1111,3, 3,1,0);
      add(0,1,0,4'b1111,3, 0,1,1);
      add(0,0,0,4'b1111,3, 0,1,0);
      // auto dwell=3: mode change clears, then every 4 cycles
      for (int i = 0; i < 4; i++) add(1,0,0,4'b1111,3, 0,1,0);
      add(1,0,0,4'b1111,3, 1,1,1);
      for (int i = 0; i < 3; i++) add(1,0,0,4'b1111,3, 1,1,0);
      add(1,0,0,4'b1111,3, 2,1,1);
      add(1,0,0,4'b1111,3, 2,1,0);
      add(1,0,0,4'b1111,3, 2,1,0);
      // hold for 6 cycles at cnt=2, then one more count and advance
      for (int i = 0; i < 6; i++) add(1,0,1,4'b1111,3, 2,1,0);
      add(1,0,0,4'b1111,3, 2,1,0);
      add(1,0,0,4'b1111,3, 3,1,1);
      for (int i = 0; i < 3; i++) add(1,0,0,4'b1111,3, 3,1,0);
      add(1,0,0,4'b1111,3, 0,1,1);
      // masked skip with dwell=0
      add(1,0,0,4'b1010,0, 1,1,1);
      add(1,0,0,4'b1010,0, 3,1,1);
      add(1,0,0,4'b1010,0, 1,1,1);
      add(1,0,0,4'b1010,0, 3,1,1);
      add(1,0,0,4'b0100,0, 2,1,1);
      add(1,0,0,4'b0100,0, 2,1,0);
      add(1,0,0,4'b0100,0, 2,1,0);
      // back to manual, step to Sel=1, then forced reselect
      add(0,0,0,4'b1111,3, 2,1,0);
      add(0,1,0,4'b1111,3, 3,1,1);
      add(0,0,0,4'b1111,3, 3,1,0);
      add(0,1,0,4'b1111,3, 0,1,1);
      add(0,0,0,4'b1111,3, 0,1,0);
      add(0,1,0,4'b1111,3, 1,1,1);
      add(0,0,0,4'b1111,3, 1,1,0);
      add(0,0,0,4'b1101,3, 2,1,1);
      add(0,0,0,4'b1101,3, 2,1,0);
      // empty mask: Enable drops, Step ignored, then recover
      add(0,0,0,4'b0000,3, 2,0,0);
      add(0,1,0,4'b0000,3, 2,0,0);
      add(0,0,0,4'b0000,3, 2,0,0);
      add(0,0,0,4'b0001,3, 0,1,1);
      // set up Sel=2 for the mid-run reset
      add(0,1,0,4'b1111,3, 1,1,1);
      add(0,0,0,4'b1111,3, 1,1,0);
      add(0,1,0,4'b1111,3, 2,1,1);

      rst_n = 1'b0;
      drive(0, 0, 0, 4'b1111, 3);
      #2;
      check_out("rst0", 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_out("rel0", 2'd0, 1'b1, 1'b0);

      foreach (vecs[i]) begin
         drive(vecs[i].mode, vecs[i].step, vecs[i].hold,
               vecs[i].mask, int'(vecs[i].dwell));
         tick();
         check_out($sformatf("vec%0d", i),
                   vecs[i].sel, vecs[i].en, vecs[i].adv);
      end

      // asynchronous reset with Sel=2, no clock edge needed
      #3;
      rst_n = 1'b0;
      #1;
      check_out("arst", 2'd0, 1'b0, 1'b0);
      bus.Step = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_out("arel", 2'd0, 1'b1, 1'b0);

      // lowering Dwell below cnt advances on the next edge
      drive(1, 0, 0, 4'b1111, 5);
      for (int i = 0; i < 5; i++) tick();
      check_out("dw_pre", 2'd0, 1'b1, 1'b0);
      bus.Dwell = CNT_W'(2);
      tick();
      check_out("dw_low", 2'd1, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
